// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel path: default RGB widths used by the
// sync generator and the sprite path, the channel slot layout of both the
// memory word and the output colour ({R,G,B}, R in the highest slot), and a
// helper that maps a logical sync assertion onto the pin level.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_COLOR_BITS     = 3;
    localparam int VGA_MEM_CH_BITS    = 4;
    localparam int VGA_RGB_WIDTH      = 3 * VGA_COLOR_BITS;
    localparam int VGA_MEM_WORD_WIDTH = 3 * VGA_MEM_CH_BITS;

    // Channel slot index; bit offset of a channel = slot * channel width.
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Pin level for a logical sync state (asserted=1 means "in sync pulse").
    function automatic logic sync_level(input bit active_low, input logic asserted);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Fixed-depth shift register with every stage cleared to RESET_VAL by the
// asynchronous active-low reset.
//   clk    in   clock
//   reset  in   asynchronous, active-low reset
//   d      in   WIDTH  data entering the line
//   q      out  WIDTH  data delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// -----------------------------------------------------------------------------
// vga_pixel_pipe
// Pixel output stage between sync generator, sprite-address generator and
// sprite memory. Registers the memory request, delays active/hit/hsync/vsync
// to meet the returning memory data, then picks texel, background or blank
// and registers the VGA pins. Input-to-pin latency is L = MEM_LATENCY + 2 for
// colour and syncs alike.
//
// Optional feature macro: VGA_PIXEL_TRANSPARENCY_EN
//   defined   : a hit whose mem_data equals key_colour shows the background
//   undefined : key_colour is ignored
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   video_enable             active-area flag
//   hsync_in, vsync_in       raw syncs (already at pin polarity)
//   ready, element, address  sprite hit / sprite index / texel address
//   bg_we, bg_colour         background shadow write {R,G,B}
//   key_colour               transparency key (memory word format)
//   mem_rd_en, mem_element,
//   mem_address              registered memory request
//   mem_data                 read data, valid MEM_LATENCY cycles after mem_rd_en
//   VGA_R/G/B, hsync, vsync  registered outputs
//
// Handshake: there is none. One pixel enters per clk and the pipe never
// stalls; mem_data is trusted to be valid exactly MEM_LATENCY cycles after
// the cycle in which mem_rd_en is high.
// -----------------------------------------------------------------------------
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int                      COLOR_BITS      = VGA_COLOR_BITS,
    parameter int                      MEM_CH_BITS     = VGA_MEM_CH_BITS,
    parameter int                      ADDR_WIDTH      = 10,
    parameter int                      ELEM_WIDTH      = 4,
    parameter int                      MEM_LATENCY     = 1,
    parameter bit                      SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [3*COLOR_BITS-1:0] BG_RESET        = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     video_enable,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     ready,
    input  logic [ELEM_WIDTH-1:0]    element,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic                     bg_we,
    input  logic [3*COLOR_BITS-1:0]  bg_colour,
    input  logic [3*MEM_CH_BITS-1:0] key_colour,
    output logic                     mem_rd_en,
    output logic [ELEM_WIDTH-1:0]    mem_element,
    output logic [ADDR_WIDTH-1:0]    mem_address,
    input  logic [3*MEM_CH_BITS-1:0] mem_data,
    output logic [COLOR_BITS-1:0]    VGA_R,
    output logic [COLOR_BITS-1:0]    VGA_G,
    output logic [COLOR_BITS-1:0]    VGA_B,
    output logic                     hsync,
    output logic                     vsync
);

    localparam int   RGB_W       = 3 * COLOR_BITS;
    // The output register supplies the last of the L stages.
    localparam int   DLY_DEPTH   = MEM_LATENCY + 1;
    localparam int   TRUNC_LSB   = MEM_CH_BITS - COLOR_BITS;
    localparam logic SYNC_IDLE   = sync_level(SYNC_ACTIVE_LOW, 1'b0);
    localparam logic SYNC_ASSERT = sync_level(SYNC_ACTIVE_LOW, 1'b1);

    // ---------------- stage 0: memory request ----------------
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ELEM_WIDTH-1:0] mem_element_q, mem_element_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;

    always_comb begin
        mem_rd_en_d   = video_enable & ready;
        mem_element_d = mem_element_q;
        mem_address_d = mem_address_q;
        if (mem_rd_en_d) begin
            mem_element_d = element;
            mem_address_d = address;
        end
    end

    // ---------------- control delay line ----------------
    logic [3:0] dly_q;
    logic       active_dly, hit_dly, hsync_dly, vsync_dly;

    pipe_delay #(
        .WIDTH     (4),
        .DEPTH     (DLY_DEPTH),
        .RESET_VAL ({1'b0, 1'b0, SYNC_IDLE, SYNC_IDLE})
    ) u_ctrl_dly (
        .clk   (clk),
        .reset (reset),
        .d     ({video_enable, ready, hsync_in, vsync_in}),
        .q     (dly_q)
    );

    assign {active_dly, hit_dly, hsync_dly, vsync_dly} = dly_q;

    // ---------------- background shadow / active ----------------
    logic             vsync_prev_q, vsync_prev_d;
    logic [RGB_W-1:0] bg_shadow_q, bg_shadow_d;
    logic [RGB_W-1:0] bg_active_q, bg_active_d;
    logic             frame_start;

    always_comb begin
        vsync_prev_d = vsync_in;
        // Frame boundary: raw vsync moving into its asserted level.
        frame_start  = (vsync_in == SYNC_ASSERT) && (vsync_prev_q != SYNC_ASSERT);
        bg_shadow_d  = bg_we ? bg_colour : bg_shadow_q;
        // The old shadow transfers even if bg_we fires in the boundary cycle.
        bg_active_d  = frame_start ? bg_shadow_q : bg_active_q;
    end

    // ---------------- output stage ----------------
    logic [RGB_W-1:0] texel;
    logic             transparent;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    // Keep the top COLOR_BITS of each memory channel (plain truncation).
    always_comb begin
        texel = '0;
        texel[CH_R*COLOR_BITS +: COLOR_BITS] = mem_data[CH_R*MEM_CH_BITS + TRUNC_LSB +: COLOR_BITS];
        texel[CH_G*COLOR_BITS +: COLOR_BITS] = mem_data[CH_G*MEM_CH_BITS + TRUNC_LSB +: COLOR_BITS];
        texel[CH_B*COLOR_BITS +: COLOR_BITS] = mem_data[CH_B*MEM_CH_BITS + TRUNC_LSB +: COLOR_BITS];
    end

`ifdef VGA_PIXEL_TRANSPARENCY_EN
    assign transparent = (mem_data == key_colour);
`else
    logic key_colour_unused;
    assign key_colour_unused = ^key_colour;
    assign transparent       = 1'b0;
`endif

    always_comb begin
        rgb_d   = '0;
        hsync_d = hsync_dly;
        vsync_d = vsync_dly;
        if (active_dly) begin
            if (hit_dly && !transparent) begin
                rgb_d = texel;
            end else begin
                rgb_d = bg_active_q;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_en_q   <= 1'b0;
            mem_element_q <= '0;
            mem_address_q <= '0;
            vsync_prev_q  <= SYNC_IDLE;
            bg_shadow_q   <= BG_RESET;
            bg_active_q   <= BG_RESET;
            rgb_q         <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
        end else begin
            mem_rd_en_q   <= mem_rd_en_d;
            mem_element_q <= mem_element_d;
            mem_address_q <= mem_address_d;
            vsync_prev_q  <= vsync_prev_d;
            bg_shadow_q   <= bg_shadow_d;
            bg_active_q   <= bg_active_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_element = mem_element_q;
    assign mem_address = mem_address_q;
    assign VGA_R       = rgb_q[CH_R*COLOR_BITS +: COLOR_BITS];
    assign VGA_G       = rgb_q[CH_G*COLOR_BITS +: COLOR_BITS];
    assign VGA_B       = rgb_q[CH_B*COLOR_BITS +: COLOR_BITS];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_pipe
// Three instances (MEM_LATENCY = 1, 2, 4) share one stimulus stream. Each
// driven pixel pushes its hand-derived expectation into one queue per
// instance, due L = MEM_LATENCY + 2 cycles later; a monitor per instance pops
// and compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_pixel_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef VGA_PIXEL_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    // ---------------- shared stimulus ----------------
    logic        video_enable = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        ready = 1'b0;
    logic [3:0]  element = '0;
    logic [9:0]  address = '0;
    logic        bg_we = 1'b0;
    logic [8:0]  bg_colour = '0;
    logic [11:0] key_colour = 12'h0F0;

    // ---------------- DUT outputs ----------------
    logic        rd1, rd2, rd4;
    logic [3:0]  el1, el2, el4;
    logic [9:0]  a1, a2, a4;
    logic [11:0] md1, md2, md4;
    logic [2:0]  r1, g1, b1, r2, g2, b2, r4, g4, b4;
    logic        hs1, vs1, hs2, vs2, hs4, vs4;

    vga_pixel_pipe #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .video_enable(video_enable), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .ready(ready), .element(element), .address(address),
        .bg_we(bg_we), .bg_colour(bg_colour), .key_colour(key_colour),
        .mem_rd_en(rd1), .mem_element(el1), .mem_address(a1), .mem_data(md1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .hsync(hs1), .vsync(vs1));

    vga_pixel_pipe #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .video_enable(video_enable), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .ready(ready), .element(element), .address(address),
        .bg_we(bg_we), .bg_colour(bg_colour), .key_colour(key_colour),
        .mem_rd_en(rd2), .mem_element(el2), .mem_address(a2), .mem_data(md2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .hsync(hs2), .vsync(vs2));

    vga_pixel_pipe #(.MEM_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .video_enable(video_enable), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .ready(ready), .element(element), .address(address),
        .bg_we(bg_we), .bg_colour(bg_colour), .key_colour(key_colour),
        .mem_rd_en(rd4), .mem_element(el4), .mem_address(a4), .mem_data(md4),
        .VGA_R(r4), .VGA_G(g4), .VGA_B(b4), .hsync(hs4), .vsync(vs4));

    // ---------------- sprite memory models ----------------
    logic [11:0] mem_tab [16];
    logic [11:0] m1_q;
    logic [11:0] m2_q [2];
    logic [11:0] m4_q [4];

    initial begin
        for (int i = 0; i < 16; i++) mem_tab[i] = 12'h000;
        mem_tab[1] = 12'hF84;   // -> 7/4/2
        mem_tab[2] = 12'h0F0;   // equals key -> 0/7/0 or background
        mem_tab[3] = 12'h5A3;   // -> 2/5/1
    end

    always @(posedge clk) begin
        m1_q    <= rd1 ? mem_tab[a1[3:0]] : 12'h000;
        m2_q[0] <= rd2 ? mem_tab[a2[3:0]] : 12'h000;
        m2_q[1] <= m2_q[0];
        m4_q[0] <= rd4 ? mem_tab[a4[3:0]] : 12'h000;
        for (int i = 1; i < 4; i++) m4_q[i] <= m4_q[i-1];
    end

    assign md1 = m1_q;
    assign md2 = m2_q[1];
    assign md4 = m4_q[3];

    // ---------------- scoreboard ----------------
    typedef struct {
        int         due;
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q2[$];
    exp_t exp_q4[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
            e = exp_q1.pop_front();
            check("L3 rgb", {7'd0, r1, g1, b1}, {7'd0, e.rgb});
            check("L3 hsync", {15'd0, hs1}, {15'd0, e.hs});
            check("L3 vsync", {15'd0, vs1}, {15'd0, e.vs});
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (exp_q2.size() > 0 && exp_q2[0].due == cyc) begin
            e = exp_q2.pop_front();
            check("L4 rgb", {7'd0, r2, g2, b2}, {7'd0, e.rgb});
            check("L4 hsync", {15'd0, hs2}, {15'd0, e.hs});
            check("L4 vsync", {15'd0, vs2}, {15'd0, e.vs});
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (exp_q4.size() > 0 && exp_q4[0].due == cyc) begin
            e = exp_q4.pop_front();
            check("L6 rgb", {7'd0, r4, g4, b4}, {7'd0, e.rgb});
            check("L6 hsync", {15'd0, hs4}, {15'd0, e.hs});
            check("L6 vsync", {15'd0, vs4}, {15'd0, e.vs});
        end
    end

    // ---------------- background model ----------------
    logic [8:0] model_shadow = 9'o777;
    logic [8:0] model_active = 9'o777;
    logic       prev_vs      = 1'b1;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ve, input logic rdy, input logic [9:0] addr,
                         input logic hs, input logic vs, input logic we,
                         input logic [8:0] bgc, input logic [8:0] texel, input logic key_hit);
        exp_t e;
        @(posedge clk);
        #1;
        video_enable = ve;
        ready        = rdy;
        address      = addr;
        element      = addr[3:0];
        hsync_in     = hs;
        vsync_in     = vs;
        bg_we        = we;
        bg_colour    = bgc;
        if (!vs && prev_vs) model_active = model_shadow;
        if (we) model_shadow = bgc;
        prev_vs = vs;
        if (!ve)                          e.rgb = 9'o000;
        else if (rdy && !(key_hit && TRANSP_EN)) e.rgb = texel;
        else                              e.rgb = model_active;
        e.hs = hs;
        e.vs = vs;
        e.due = cyc + 3; exp_q1.push_back(e);
        e.due = cyc + 4; exp_q2.push_back(e);
        e.due = cyc + 6; exp_q4.push_back(e);
    endtask

    task automatic idle(input int n, input logic vs);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'd0, 1'b1, vs, 1'b0, 9'o0, 9'o0, 1'b0);
    endtask

    task automatic miss(input int n, input logic hs);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 10'd0, hs, 1'b1, 1'b0, 9'o0, 9'o0, 1'b0);
    endtask

    task automatic hit(input logic [9:0] addr, input logic [8:0] texel, input logic key_hit, input logic hs);
        drive(1'b1, 1'b1, addr, hs, 1'b1, 1'b0, 9'o0, texel, key_hit);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " L3 rgb"}, {7'd0, r1, g1, b1}, 16'd0);
        check({tag, " L4 rgb"}, {7'd0, r2, g2, b2}, 16'd0);
        check({tag, " L6 rgb"}, {7'd0, r4, g4, b4}, 16'd0);
        check({tag, " syncs"}, {10'd0, hs1, vs1, hs2, vs2, hs4, vs4}, 16'h003F);
        check({tag, " mem_rd_en"}, {13'd0, rd1, rd2, rd4}, 16'd0);
        check({tag, " mem_address"}, {6'd0, a1}, 16'd0);
    endtask

    task automatic wait_drain();
        int left;
        for (int i = 0; i < 40; i++) begin
            if (exp_q1.size() + exp_q2.size() + exp_q4.size() == 0) break;
            @(posedge clk);
        end
        left = exp_q1.size() + exp_q2.size() + exp_q4.size();
        check("scoreboard drain (pending entries)", left[15:0], 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 reset = 1'b0;
        #2 check_reset("power-on reset");
        @(posedge clk); #1 reset = 1'b1;

        // Blank, syncs idle-high for 100 cycles.
        idle(100, 1'b1);

        // Texel hits against the reset background; hsync falls with the first hit.
        miss(3, 1'b1);
        hit(10'd1, 9'o742, 1'b0, 1'b0);
        miss(2, 1'b0);
        miss(1, 1'b1);
        hit(10'd3, 9'o251, 1'b0, 1'b1);
        hit(10'd2, 9'o070, 1'b1, 1'b1);
        miss(1, 1'b1);

        // Mid-frame background write: no visible change this frame.
        drive(1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 9'o123, 9'o0, 1'b0);
        miss(4, 1'b1);
        hit(10'd2, 9'o070, 1'b1, 1'b1);

        // Frame boundary -> background becomes 1/2/3.
        idle(8, 1'b1);
        idle(4, 1'b0);
        idle(8, 1'b1);
        miss(3, 1'b1);
        hit(10'd1, 9'o742, 1'b0, 1'b1);
        hit(10'd2, 9'o070, 1'b1, 1'b1);
        miss(1, 1'b1);

        // Write in the boundary cycle: old shadow (1/2/3) stays, 4/5/6 waits a frame.
        idle(8, 1'b1);
        drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 9'o456, 9'o0, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);
        miss(2, 1'b1);
        idle(8, 1'b1);
        idle(3, 1'b0);
        idle(8, 1'b1);
        miss(3, 1'b1);

        // Reset in the middle of an active line.
        wait_drain();
        check("pre-reset L3 rgb", {7'd0, r1, g1, b1}, {7'd0, 9'o456});
        @(posedge clk); #3 reset = 1'b0;
        #1 check_reset("mid-line reset");
        exp_q1.delete();
        exp_q2.delete();
        exp_q4.delete();
        model_shadow = 9'o777;
        model_active = 9'o777;
        prev_vs      = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        miss(2, 1'b1);
        hit(10'd1, 9'o742, 1'b0, 1'b0);
        miss(2, 1'b1);
        idle(2, 1'b1);

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
